local_hist_table: RTL and testbench
===================================

# local_hist_table

Local History Table (LHT) for the fetch-stage local branch predictor. It sits directly upstream of the pattern history table. It holds one HISTWIDTH-bit taken/not-taken history per PC-indexed entry and returns that history one cycle after a fetch lookup; the history is used as the PHT read index. At commit it shifts the resolved branch direction into the addressed entry's history. After reset it runs a self-clearing sweep and holds `lht_ready_o` low until the table is initialized.

## Interface
- LHTSIZE, 1024, number of history entries
- LOGLHTSIZE, 10, entry index width (log2 LHTSIZE)
- HISTWIDTH, 10, bits of history per entry; equals the PHT index width
- clock  in  1  clock, all state changes on the rising edge
- reset_n  in  1  reset, asynchronous, active-low
- lht_rd_valid_i  in  1  fetch lookup request this cycle
- lht_rd_index_i  in  LOGLHTSIZE  fetch PC index bits of the entry to read
- lht_hist_o  out  HISTWIDTH  registered history of the looked-up entry, drives the PHT read index
- lht_hist_valid_o  out  1  lht_hist_o carries the result of the previous cycle's accepted lookup
- lht_cm_we_i  in  1  retired conditional branch, update the entry
- lht_cm_index_i  in  LOGLHTSIZE  PC index bits of the retired branch
- lht_cm_brdir_i  in  1  resolved direction of the retired branch (1 = taken)
- lht_ready_o  out  1  table initialized; lookups and updates are accepted

## Operation
- Storage: LHTSIZE x HISTWIDTH registers. The array has no reset value; it is cleared by the init sweep.
- FSM has two states, INIT and RUN.
  - reset_n low → INIT, sweep counter = 0.
  - In INIT, each cycle writes 0 to entry[counter] and increments counter.
  - When counter == LHTSIZE-1, that entry is written and the FSM goes to RUN on the same edge.
  - RUN holds until reset.
- lht_ready_o = 1 only in RUN. It is a registered output, so it rises the cycle after the last sweep write.
- In INIT, lookups and commits are ignored: no array write from commit, and lht_hist_valid_o stays 0.
- Lookup, accepted when ready and lht_rd_valid_i:
  - next lht_hist_o = entry[lht_rd_index_i]
  - next lht_hist_valid_o = 1
- With no accepted lookup, lht_hist_valid_o → 0 and lht_hist_o holds its last value.
- Commit, accepted when ready and lht_cm_we_i: entry[cm_index] ← {entry[cm_index][HISTWIDTH-2:0], lht_cm_brdir_i}. The new direction enters at the LSB and the oldest bit is dropped.
- Read/commit same cycle, same index: the lookup returns the post-update value (write-first bypass).
- Read/commit same cycle, different index: both proceed independently.
- Back-to-back commits to one index: each shift uses the value written on the previous edge, so no direction is lost.
- Index widths are exact; no wrap or truncation is needed. The sweep counter is LOGLHTSIZE bits wide and never wraps, because the FSM leaves INIT at LHTSIZE-1.

## Timing
- Reset values: lht_hist_o = 0, lht_hist_valid_o = 0, lht_ready_o = 0, FSM = INIT, counter = 0.
- Init duration: LHTSIZE cycles after reset_n deasserts. lht_ready_o = 1 in cycle LHTSIZE+1, counting the first clock edge after deassertion as edge 1.
- Lookup latency is 1 cycle: request at edge N, result valid in the cycle after edge N.
- Commit latency is 1 cycle: the entry is updated at edge N, and a lookup to the same index at edge N+1 returns the new value. A lookup at edge N also returns the new value through the bypass.
- Reset asserted mid-operation: all outputs drop to reset values immediately (asynchronous). A full re-sweep follows, and any in-flight lookup result is discarded.
- No backpressure. Requests during INIT are dropped, not queued. The fetch stage must gate its lookups on lht_ready_o.

## Test plan
- Reset/init: deassert reset_n, sample every cycle → lht_ready_o = 0 for 1024 cycles then 1. A lookup of index 0x3FF after ready → lht_hist_o = 0x000 with valid = 1.
- Shift update: commit index 0x155 with directions 1,1,0,1 on 4 consecutive cycles, then look up 0x155 → lht_hist_o = 0x00D.
- Saturation of width: 12 taken commits to index 7 → history = 0x3FF. One not-taken commit → 0x3FE.
- Bypass: entry 0x020 = 0x001; same cycle lookup 0x020 plus commit 0x020 taken → next-cycle lht_hist_o = 0x003. Same cycle lookup 0x021 → that entry's old value, unchanged.
- Ignored during INIT: commits and lookups issued while lht_ready_o = 0 → valid stays 0, and after ready every entry reads 0x000.
- Mid-run reset: set entry 5 to 0x2AA, pulse reset_n low for 1 cycle → outputs at reset values immediately, ready low for 1024 cycles, then entry 5 reads 0x000.

Source files
------------

// File: rtl/local_hist_table.sv
// Local history table: per-entry taken/not-taken shift history read at fetch and updated at commit.
// Lookup latency 1 cycle, with write-first bypass from a same-cycle commit to the same entry.
// No backpressure; requests arriving before the post-reset clearing sweep completes are dropped.
module local_hist_table #(
    parameter int LHTSIZE    = 1024,
    parameter int LOGLHTSIZE = 10,
    parameter int HISTWIDTH  = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  lht_rd_valid_i,
    input  logic [LOGLHTSIZE-1:0] lht_rd_index_i,
    output logic [HISTWIDTH-1:0]  lht_hist_o,
    output logic                  lht_hist_valid_o,
    input  logic                  lht_cm_we_i,
    input  logic [LOGLHTSIZE-1:0] lht_cm_index_i,
    input  logic                  lht_cm_brdir_i,
    output logic                  lht_ready_o
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                r_state;
    logic [LOGLHTSIZE-1:0] r_cnt;
    logic [HISTWIDTH-1:0]  r_mem [LHTSIZE];
    logic [HISTWIDTH-1:0]  r_hist;
    logic                  r_hist_vld;
    logic                  r_ready;

    logic [HISTWIDTH-1:0]  w_cm_new;
    logic [HISTWIDTH-1:0]  w_rd_hist;
    logic                  w_run;

    assign w_run    = (r_state == ST_RUN);
    assign w_cm_new = {r_mem[lht_cm_index_i][HISTWIDTH-2:0], lht_cm_brdir_i};

    // Same-entry commit wins so the PHT index already reflects the retiring branch.
    assign w_rd_hist = (lht_cm_we_i && (lht_cm_index_i == lht_rd_index_i))
                       ? w_cm_new : r_mem[lht_rd_index_i];

    // Storage has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clock) begin
        if (!w_run) begin
            r_mem[r_cnt] <= '0;
        end else if (lht_cm_we_i) begin
            r_mem[lht_cm_index_i] <= w_cm_new;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_cnt      <= '0;
            r_hist     <= '0;
            r_hist_vld <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_hist_vld <= 1'b0;
                    r_cnt      <= r_cnt + LOGLHTSIZE'(1);
                    if (r_cnt == LOGLHTSIZE'(LHTSIZE - 1)) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_hist_vld <= lht_rd_valid_i;
                    if (lht_rd_valid_i) begin
                        r_hist <= w_rd_hist;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign lht_hist_o       = r_hist;
    assign lht_hist_valid_o = r_hist_vld;
    assign lht_ready_o      = r_ready;

endmodule

// File: tb/tb_local_hist_table.sv
// Bench for local_hist_table: table-driven vectors checked through an expected-result queue.
module tb_local_hist_table;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rd_valid = 1'b0;
    logic [9:0] rd_index = '0;
    logic [9:0] hist;
    logic       hist_valid;
    logic       cm_we = 1'b0;
    logic [9:0] cm_index = '0;
    logic       cm_brdir = 1'b0;
    logic       ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_q[$];
    logic [9:0] last_hist = '0;

    typedef struct {
        logic       rv;
        logic [9:0] ri;
        logic       cw;
        logic [9:0] ci;
        logic       cd;
        logic       ev;
        logic [9:0] eh;
    } vec_t;

    vec_t tbl[$];

    local_hist_table #(.LHTSIZE(1024), .LOGLHTSIZE(10), .HISTWIDTH(10)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .lht_rd_valid_i   (rd_valid),
        .lht_rd_index_i   (rd_index),
        .lht_hist_o       (hist),
        .lht_hist_valid_o (hist_valid),
        .lht_cm_we_i      (cm_we),
        .lht_cm_index_i   (cm_index),
        .lht_cm_brdir_i   (cm_brdir),
        .lht_ready_o      (ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, queue the expected lookup result, then check after the edge.
    task automatic cycle(input logic rv, input logic [9:0] ri, input logic cw,
                         input logic [9:0] ci, input logic cd,
                         input logic ev, input logic [9:0] eh);
        logic [9:0] e;
        rd_valid = rv; rd_index = ri;
        cm_we = cw; cm_index = ci; cm_brdir = cd;
        if (ev) exp_q.push_back(eh);
        @(posedge clock); #1;
        rd_valid = 1'b0; cm_we = 1'b0;
        check("hist_valid", int'(hist_valid), int'(ev));
        if (hist_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("hist", int'(hist), int'(e));
                last_hist = e;
            end
        end else begin
            check("hist_hold", int'(hist), int'(last_hist));
        end
    endtask

    // Async reset with an in-flight lookup presented; outputs must drop before any edge.
    task automatic do_reset();
        rd_valid = 1'b1; rd_index = 10'd5;
        reset_n = 1'b0;
        #1;
        check("rst_hist", int'(hist), 0);
        check("rst_valid", int'(hist_valid), 0);
        check("rst_ready", int'(ready), 0);
        exp_q.delete();
        last_hist = '0;
        @(posedge clock); #1;
        rd_valid = 1'b0;
        reset_n = 1'b1;
    endtask

    // Sweep: ready must stay low through edge 1023 and be high after edge 1024.
    task automatic init_sweep(input logic junk);
        for (int k = 1; k <= 1024; k++) begin
            if (junk)
                cycle(1'b1, 10'($urandom_range(1023)), 1'b1, 10'($urandom_range(1023)),
                      1'b1, 1'b0, 10'd0);
            else
                cycle(1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
            check($sformatf("ready_edge%0d", k), int'(ready), (k == 1024) ? 1 : 0);
        end
    endtask

    function automatic void add(input logic rv, input logic [9:0] ri, input logic cw,
                                input logic [9:0] ci, input logic cd,
                                input logic ev, input logic [9:0] eh);
        tbl.push_back('{rv, ri, cw, ci, cd, ev, eh});
    endfunction

    initial begin
        // Shift update: 1,1,0,1 -> 0b1101
        add(0, 0, 1, 10'h155, 1, 0, 0);
        add(0, 0, 1, 10'h155, 1, 0, 0);
        add(0, 0, 1, 10'h155, 0, 0, 0);
        add(0, 0, 1, 10'h155, 1, 0, 0);
        add(1, 10'h155, 0, 0, 0, 1, 10'h00D);
        add(0, 0, 0, 0, 0, 0, 0);
        // Width saturation on entry 7
        for (int i = 0; i < 12; i++) add(0, 0, 1, 10'd7, 1, 0, 0);
        add(1, 10'd7, 0, 0, 0, 1, 10'h3FF);
        add(0, 0, 1, 10'd7, 0, 0, 0);
        add(1, 10'd7, 0, 0, 0, 1, 10'h3FE);
        // Bypass and independent indices
        add(0, 0, 1, 10'h020, 1, 0, 0);
        add(1, 10'h020, 0, 0, 0, 1, 10'h001);
        add(1, 10'h020, 1, 10'h020, 1, 1, 10'h003);
        add(1, 10'h021, 1, 10'h020, 1, 1, 10'h000);
        add(1, 10'h020, 0, 0, 0, 1, 10'h007);
        add(1, 10'h020, 1, 10'h021, 1, 1, 10'h007);
        add(1, 10'h021, 0, 0, 0, 1, 10'h001);
        add(1, 10'h3FF, 0, 0, 0, 1, 10'h000);
        add(0, 0, 0, 0, 0, 0, 0);

        #2;
        do_reset();
        init_sweep(1'b1);

        // Every entry cleared despite commits issued during the sweep.
        for (int i = 0; i < 1024; i++)
            cycle(1'b1, 10'(i), 1'b0, 10'd0, 1'b0, 1'b1, 10'd0);

        for (int i = 0; i < tbl.size(); i++)
            cycle(tbl[i].rv, tbl[i].ri, tbl[i].cw, tbl[i].ci, tbl[i].cd, tbl[i].ev, tbl[i].eh);

        // Mid-run reset: entry 5 = 0x2AA, then reset must clear it and the outputs.
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 10'd0, 1'b1, 10'd5, ((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0, 10'd0);
        cycle(1'b1, 10'd5, 1'b0, 10'd0, 1'b0, 1'b1, 10'h2AA);
        do_reset();
        init_sweep(1'b0);
        cycle(1'b1, 10'd5, 1'b0, 10'd0, 1'b0, 1'b1, 10'h000);
        cycle(1'b1, 10'h155, 1'b0, 10'd0, 1'b0, 1'b1, 10'h000);
        cycle(1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
